sad_fsm: RTL and testbench
==========================

// Module: sad_fsm
// PURPOSE
//   Control FSM for the SAD (sum-of-absolute-differences) datapath.
//   Waits for a go pulse, clears the datapath counter/accumulator, then enables
//   accumulation until the datapath comparator reports completion.
//   Finally loads the SAD result register and returns to idle.
//   Sits between the top-level start logic and the SAD datapath.
// PARAMETERS
//   (none) -- state encoding is fixed:
//     IDLE=2'b00, CLEAR=2'b01, ACCUM=2'b10, LOAD=2'b11
// PORTS
//   clk     in   1  system clock; all state changes occur on the rising edge
//   Mrst    in   1  asynchronous, active-low master reset
//   go      in   1  start request, sampled only in IDLE; level or 1-cycle pulse
//   comp    in   1  datapath compare flag; 1 = count complete, 0 = keep accumulating
//   rst     out  1  active-high synchronous clear for datapath counter and sum
//   en      out  1  enable for the datapath counter increment and sum accumulate
//   en_reg  out  1  load strobe for the SAD output register
// BEHAVIOUR
//   - Interface: one clock (clk); reset Mrst is asynchronous and active-low.
//   - Mrst=0 forces state=IDLE immediately, regardless of clk.
//     All outputs are 0 while Mrst=0.
//   - Mrst released mid-operation: the FSM restarts in IDLE. No partial LOAD is issued.
//   - State register is 2 bits and updates on posedge clk when Mrst=1.
//   - Transitions:
//       IDLE  -> CLEAR if go=1 at the edge; otherwise stay in IDLE
//       CLEAR -> ACCUM unconditionally (exactly one cycle)
//       ACCUM -> LOAD  if comp=1 at the edge; otherwise stay in ACCUM
//       LOAD  -> IDLE  unconditionally (exactly one cycle)
//   - Outputs are decoded combinationally from state; no output registers.
//       rst    = (state==CLEAR)
//       en     = (state==ACCUM) & ~comp   (gated so the datapath never overcounts)
//       en_reg = (state==LOAD)
//   - go is ignored outside IDLE; a go held high through LOAD starts a new run
//     on the edge following the return to IDLE.
//   - comp is ignored outside ACCUM.
//     If comp=1 on the first ACCUM cycle: en stays 0, then LOAD follows.
//   - Latency, go edge to en_reg high: 3 cycles minimum
//     (CLEAR, ACCUM, LOAD), plus 1 cycle per ACCUM cycle with comp=0.
//   - At most one of rst/en/en_reg is high at any time.
//   - Illegal or unknown state: recover to IDLE on the next edge.
//     This case is unreachable with the 2-bit encoding but still covered by a default branch.
// TESTING
//   1. Mrst=0 at t=0 with go=1 -> state IDLE; rst=en=en_reg=0 throughout reset.
//   2. Release reset, pulse go for 1 cycle, comp=0 -> next cycle rst=1 for exactly
//      1 cycle; then en=1 continuously.
//   3. Continuing from 2: hold comp=0 for 15 cycles, then set comp=1 -> en drops
//      immediately (same cycle); en_reg=1 for exactly 1 cycle; then IDLE with all outputs 0.
//   4. go=1 with comp already 1 -> sequence is rst(1 cycle), ACCUM with en=0 (1 cycle),
//      en_reg(1 cycle), then IDLE.
//   5. Assert Mrst=0 asynchronously mid-ACCUM (between clock edges) -> en falls
//      without waiting for clk; after release the FSM stays in IDLE until the next go.
//   6. Hold go=1 continuously -> back-to-back runs; IDLE lasts 1 cycle between
//      en_reg and the next rst.

Source files
------------

// File: rtl/sad_fsm.sv
// Control FSM for the SAD datapath: IDLE -> CLEAR -> ACCUM (until comp) -> LOAD -> IDLE.
// Outputs are decoded from the state register; en is additionally gated by comp.
module sad_fsm (
   input  logic clk,
   input  logic Mrst,
   input  logic go,
   input  logic comp,
   output logic rst,
   output logic en,
   output logic en_reg
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CLEAR = 2'b01,
      ACCUM = 2'b10,
      LOAD  = 2'b11
   } state_t;

   state_t state_q;
   state_t state_d;

   always_comb begin
      // NOTE: default assignment first so every path drives state_d and no latch is inferred.
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = go   ? CLEAR : IDLE;
         CLEAR:   state_d = ACCUM;
         ACCUM:   state_d = comp ? LOAD  : ACCUM;
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; Mrst clears it without waiting for clk.
   always_ff @(posedge clk or negedge Mrst) begin
      if (!Mrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // en drops in the same cycle comp rises so the datapath never counts one extra element.
   assign rst    = (state_q == CLEAR);
   assign en     = (state_q == ACCUM) & ~comp;
   assign en_reg = (state_q == LOAD);

endmodule

// File: tb/tb_sad_fsm.sv
// Self-checking bench for sad_fsm: run-level behavioural model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_sad_fsm;

   logic clk = 1'b0;
   logic Mrst, go, comp;
   logic rst, en, en_reg;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_on   = 1'b0;

   sad_fsm dut (
      .clk    (clk),
      .Mrst   (Mrst),
      .go     (go),
      .comp   (comp),
      .rst    (rst),
      .en     (en),
      .en_reg (en_reg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a run is a count of cycles since go was accepted; it ends with one load cycle.
   bit running = 1'b0;
   bit loading = 1'b0;
   int age     = 0;

   always @(posedge clk or negedge Mrst) begin
      if (!Mrst) begin
         running = 1'b0; loading = 1'b0; age = 0;
      end else if (loading) begin
         running = 1'b0; loading = 1'b0; age = 0;
      end else if (running) begin
         if (age >= 2 && comp) loading = 1'b1;
         age++;
      end else if (go) begin
         running = 1'b1; age = 1;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("model_rst",    rst,    running && !loading && age == 1);
         check("model_en",     en,     running && !loading && age >= 2 && !comp);
         check("model_en_reg", en_reg, loading);
         check("one_hot", ($countones({rst, en, en_reg}) <= 1), 1'b1);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [11:0] rst_hist, reg_hist;

   initial begin
      // 1: reset held with go=1
      Mrst = 1'b0; go = 1'b1; comp = 1'b0;
      cmp_on = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("reset_rst",    rst,    1'b0);
         check("reset_en",     en,     1'b0);
         check("reset_en_reg", en_reg, 1'b0);
      end

      // 2: release, single go pulse, comp=0
      Mrst = 1'b1; go = 1'b0;
      cyc();
      check("idle_after_release", rst | en | en_reg, 1'b0);
      go = 1'b1;
      cyc();
      go = 1'b0;
      check("clear_rst", rst, 1'b1);
      check("clear_en",  en,  1'b0);
      cyc();
      check("accum_rst_low", rst, 1'b0);
      check("accum_en",      en,  1'b1);

      // 3: 15 accumulate cycles, then comp=1
      for (int i = 0; i < 15; i++) begin
         cyc();
         check("accum_hold_en", en, 1'b1);
      end
      comp = 1'b1;
      #1;
      check("en_drops_on_comp", en,     1'b0);
      check("no_load_yet",      en_reg, 1'b0);
      cyc();
      comp = 1'b0;
      check("load_en_reg", en_reg, 1'b1);
      cyc();
      check("post_load_en_reg", en_reg, 1'b0);
      check("post_load_idle",   rst | en, 1'b0);
      cyc();
      check("idle_stays", rst | en | en_reg, 1'b0);

      // 4: go with comp already high
      comp = 1'b1; go = 1'b1;
      cyc();
      go = 1'b0;
      check("fast_clear", rst, 1'b1);
      cyc();
      check("fast_accum_en",  en,     1'b0);
      check("fast_accum_rst", rst,    1'b0);
      check("fast_accum_reg", en_reg, 1'b0);
      cyc();
      check("fast_load", en_reg, 1'b1);
      cyc();
      check("fast_idle", rst | en | en_reg, 1'b0);
      comp = 1'b0;

      // 5: asynchronous reset mid-ACCUM
      go = 1'b1;
      cyc();
      go = 1'b0;
      cyc();
      check("pre_async_en", en, 1'b1);
      #3;
      Mrst = 1'b0;
      #1;
      check("async_en_falls", en, 1'b0);
      cyc();
      Mrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("post_async_idle", rst | en | en_reg, 1'b0);
      end
      go = 1'b1;
      cyc();
      go = 1'b0;
      check("restart_clear", rst, 1'b1);
      comp = 1'b1;
      cyc(); cyc(); cyc();
      check("restart_done_idle", rst | en | en_reg, 1'b0);

      // 6: go held high, back-to-back runs with comp=1
      go = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         rst_hist[i] = rst;
         reg_hist[i] = en_reg;
      end
      go = 1'b0; comp = 1'b0;
      // Period of 4: CLEAR, ACCUM, LOAD, IDLE starting at cycle 0.
      check("b2b_rst_pattern",    rst_hist == 12'b0001_0001_0001, 1'b1);
      check("b2b_en_reg_pattern", reg_hist == 12'b0100_0100_0100, 1'b1);

      cyc(); cyc(); cyc();
      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
